// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encodings, response codes and register-index sizing.
package apb_pkg;

  // Completer transfer FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } cmp_state_t;

  // Master transfer FSM, kept here so both sides of the bus share one definition
  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2
  } mst_state_t;

  // PSLVERR encodings
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Number of index bits needed to address n registers (at least 1)
  function automatic int unsigned clog2_regs(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register bank: read-only ID at index 0, read/write storage for the rest.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = clog2_regs(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [IDX_W-1:0]               ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

  // Storage update: clear on reset, otherwise write the addressed register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (widx == IDX_W'(i)) mem[i] <= wdata;
      end
    end
  end

  // Read mux with the ID constant at index 0
  always_comb begin
    rdata = ID_VALUE;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) rdata = mem[i];
    end
  end

  // Parallel export of every register
  always_comb begin
    regs_flat = '0;
    regs_flat[0 +: DATA_WIDTH] = ID_VALUE;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end
  end

endmodule

// File: rtl/apb_completer.sv
// APB3 completer: word register bank with wait states and error responses.
module apb_completer
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int unsigned IDX_W     = clog2_regs(NUM_REGS);
  localparam logic [3:0]  WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  cmp_state_t            state, state_n;
  logic [3:0]            wcnt, wcnt_n;
  logic [IDX_W-1:0]      idx_d, idx_q, ridx;
  logic                  err_d, err_q, wr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  setup, enter_resp, resp_err, resp_wr, commit;

  assign setup     = PSEL && !PENABLE;
  assign word_addr = PADDR >> 2;
  assign idx_d     = PADDR[2 +: IDX_W];
  assign err_d     = (PADDR[1:0] != 2'b00)
                  || (word_addr >= ADDR_WIDTH'(NUM_REGS))
                  || (PWRITE && (idx_d == '0));

  // With no wait states the response launches from IDLE on the setup edge,
  // before the request is latched, so the live decode feeds the response there.
  assign resp_err   = (state == ST_IDLE) ? err_d  : err_q;
  assign resp_wr    = (state == ST_IDLE) ? PWRITE : wr_q;
  assign ridx       = (state == ST_IDLE) ? idx_d  : idx_q;
  assign enter_resp = (state_n == ST_RESP);
  assign commit     = (state == ST_RESP) && PSEL && PENABLE && wr_q && !err_q;

  apb_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regbank (
    .clk       (PCLK),
    .rst       (PRESET),
    .we        (commit),
    .widx      (idx_q),
    .wdata     (wdata_q),
    .ridx      (ridx),
    .rdata     (rdata),
    .regs_flat (regs_flat)
  );

  // Next-state and wait-counter logic; PSEL low outside IDLE aborts to IDLE
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      ST_IDLE: begin
        if (setup) begin
          if (WAIT_STATES > 0) begin
            state_n = ST_WAIT;
            wcnt_n  = WCNT_INIT;
          end else begin
            state_n = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_n = ST_IDLE;
          wcnt_n  = '0;
        end else if (wcnt == '0) begin
          state_n = ST_RESP;
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register, request latches and registered response outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= RESP_OKAY;
      PRDATA  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      PREADY  <= enter_resp;
      PSLVERR <= (enter_resp && resp_err) ? RESP_ERROR : RESP_OKAY;
      PRDATA  <= (enter_resp && !resp_err && !resp_wr) ? rdata : '0;
      if ((state == ST_IDLE) && setup) begin
        idx_q   <= idx_d;
        wr_q    <= PWRITE;
        err_q   <= err_d;
        wdata_q <= PWDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Scoreboard bench: one lane with one wait state, one lane with none.
module tb_apb_completer;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic        commit;
    logic [3:0]  idx;
    logic [31:0] wdata;
  } exp_t;

  logic PCLK;
  int   compared = 0;
  int   mismatched = 0;
  int   lanes_done = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WS = (g == 0) ? 1 : 0;

    logic         preset, psel, penable, pwrite;
    logic [31:0]  paddr, pwdata, prdata;
    logic         pready, pslverr;
    logic [511:0] regs_flat;

    exp_t         q[$];
    logic [31:0]  mdl [16];
    logic [31:0]  shadow [16];
    logic [511:0] sflat;
    exp_t         me;
    bit           armed = 0;
    bit           pend_w = 0;
    bit           pend_clr = 0;
    logic [3:0]   pend_idx;
    logic [31:0]  pend_d;
    logic [31:0]  ra, rd;
    logic         rw;
    int unsigned  sel;

    apb_completer #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .NUM_REGS    (16),
      .WAIT_STATES (WS),
      .ID_VALUE    (ID)
    ) dut (
      .PCLK      (PCLK),
      .PRESET    (preset),
      .PSEL      (psel),
      .PENABLE   (penable),
      .PWRITE    (pwrite),
      .PADDR     (paddr),
      .PWDATA    (pwdata),
      .PRDATA    (prdata),
      .PREADY    (pready),
      .PSLVERR   (pslverr),
      .regs_flat (regs_flat)
    );

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp_v);
      compared++;
      if (act !== exp_v) begin
        mismatched++;
        $display("FAIL lane%0d %s: got %0h expected %0h", g, nm, act, exp_v);
      end
    endtask

    // Reference model: APB register-file rules applied at issue time
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit keep, output exp_t e);
      int unsigned wi;
      wi       = a >> 2;
      e.err    = (a[1:0] != 2'b00) || (wi >= 16) || (w && (wi == 0));
      e.data   = (e.err || w) ? 32'h0 : mdl[wi];
      e.commit = w && !e.err && keep;
      e.idx    = wi[3:0];
      e.wdata  = d;
      if (e.commit) mdl[wi] = d;
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
      end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      model(w, a, d, 1'b1, e);
      q.push_back(e);
      @(posedge PCLK); #1;
      penable = 1'b1;
      n = 0;
      do begin
        @(negedge PCLK);
        n++;
      end while (!pready && n < 40);
      check("access_cycles", 512'(n), 512'(WS + 1));
    endtask

    // PSEL dropped in the first access cycle
    task automatic xfer_abort(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      model(1'b1, a, d, 1'b0, e);
      // without wait states the first access cycle already carries PREADY
      if (WS == 0) q.push_back(e);
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      idle(3);
    endtask

    task automatic reset_mid(input logic [31:0] d);
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = d;
      if (WS > 0) begin
        @(posedge PCLK); #1;
        penable = 1'b1;
      end
      preset = 1'b1;
      @(posedge PCLK); #1;
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      for (int i = 1; i < 16; i++) mdl[i] = 32'h0;
      @(negedge PCLK);
      check("pready_after_reset", 512'(pready), 512'(0));
      check("reg4_after_reset", 512'(regs_flat[4*32 +: 32]), 512'(0));
    endtask

    // Monitor: registers, response pops and idle-output rules each cycle
    always @(negedge PCLK) begin
      if (armed) begin
        if (pend_clr) begin
          for (int i = 1; i < 16; i++) shadow[i] = 32'h0;
        end else if (pend_w) begin
          shadow[pend_idx] = pend_d;
        end
        pend_clr = 0;
        pend_w   = 0;
        for (int i = 0; i < 16; i++) sflat[i*32 +: 32] = shadow[i];
        check("regs_flat", regs_flat, sflat);
        if (pready) begin
          if (q.size() == 0) begin
            check("unexpected_pready", 512'(pready), 512'(0));
          end else begin
            me = q.pop_front();
            check("pslverr", 512'(pslverr), 512'(me.err));
            check("prdata", 512'(prdata), 512'(me.data));
            if (me.commit) begin
              pend_w   = 1;
              pend_idx = me.idx;
              pend_d   = me.wdata;
            end
          end
        end else begin
          check("pslverr_idle", 512'(pslverr), 512'(0));
          check("prdata_idle", 512'(prdata), 512'(0));
        end
        if (preset) pend_clr = 1;
      end
    end

    initial begin
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      mdl[0] = ID; shadow[0] = ID;
      for (int i = 1; i < 16; i++) begin
        mdl[i] = 32'h0;
        shadow[i] = 32'h0;
      end
      repeat (3) @(posedge PCLK);
      #1;
      preset = 1'b0;
      armed = 1;
      idle(2);

      xfer(1'b1, 32'h04, 32'hDEADBEEF);
      xfer(1'b0, 32'h04, 32'h0);
      idle(2);
      check("reg1_deadbeef", 512'(regs_flat[63:32]), 512'(32'hDEADBEEF));
      xfer(1'b1, 32'h08, 32'h1111_2222);
      xfer(1'b1, 32'h0C, 32'h3333_4444);
      xfer(1'b0, 32'h08, 32'h0);
      xfer(1'b0, 32'h0C, 32'h0);
      xfer(1'b0, 32'h00, 32'h0);
      xfer(1'b1, 32'h00, 32'h5555_AAAA);
      xfer(1'b0, 32'h00, 32'h0);
      xfer(1'b1, 32'h40, 32'hCAFE_F00D);
      xfer(1'b0, 32'h40, 32'h0);
      xfer(1'b1, 32'h06, 32'hBAD0_0006);
      xfer(1'b0, 32'h06, 32'h0);
      idle(1);

      xfer(1'b1, 32'h10, 32'h0404_0404);
      idle(1);
      reset_mid(32'h7777_8888);
      xfer(1'b0, 32'h10, 32'h0);
      xfer(1'b1, 32'h10, 32'h1234_5678);
      xfer(1'b0, 32'h10, 32'h0);

      idle(1);
      xfer_abort(32'h14, 32'hABAB_ABAB);
      xfer(1'b0, 32'h14, 32'h0);
      xfer(1'b1, 32'h14, 32'h1414_1414);
      xfer(1'b0, 32'h14, 32'h0);

      // PENABLE without a setup phase must be ignored
      idle(1);
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'hEEEE_0018;
      @(posedge PCLK); #1;
      idle(3);

      for (int k = 0; k < 60; k++) begin
        sel = $urandom_range(0, 9);
        rw  = 1'($urandom_range(0, 1));
        rd  = $urandom();
        if (sel <= 5) begin
          ra = 32'($urandom_range(1, 15)) << 2;
        end else if (sel == 6) begin
          ra = 32'h0;
        end else if (sel == 7) begin
          ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        end else if (sel == 8) begin
          ra = $urandom();
          ra[1:0] = 2'b00;
          ra[6] = 1'b1;
        end else begin
          ra = $urandom();
        end
        xfer(rw, ra, rd);
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(4);
      check("queue_drained", 512'(q.size()), 512'(0));
      lanes_done++;
    end
  end

  initial begin
    int n;
    n = 0;
    while (lanes_done < 2 && n < 20000) begin
      @(posedge PCLK);
      n++;
    end
    compared++;
    if (lanes_done < 2) begin
      mismatched++;
      $display("FAIL timeout: lanes finished %0d expected 2", lanes_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
# apb_completer

APB3 completer (slave) that answers transfers from the team's APB master on the same PCLK domain. It holds a small bank of word-addressed registers and inserts a parameterised number of wait states via PREADY. It flags PSLVERR on out-of-range or misaligned addresses and on writes to the read-only ID register. Register contents are exported in parallel so downstream logic can use them as configuration.

## Interface
- ADDR_WIDTH, 32: width of PADDR.
- DATA_WIDTH, 32: width of PWDATA/PRDATA and of each register.
- NUM_REGS, 16: number of registers, at least 2, at byte offsets 4*i.
- WAIT_STATES, 1: access-phase cycles with PREADY low before completion; 0..15.
- ID_VALUE, 32'hA9B0_0001: constant value of register 0, which is read-only.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer completion, registered.
- PSLVERR  out  1  error response, valid only while PREADY=1.
- regs_flat  out  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - Setup phase (PSEL=1, PENABLE=0) latches PADDR, PWRITE and PWDATA, and decodes the error.
  - Goes to WAIT with wcnt=WAIT_STATES-1 when WAIT_STATES>0, otherwise goes to RESP.
  - Any other input combination stays in IDLE.
- WAIT: while PSEL=1, decrement wcnt; at wcnt=0 go to RESP.
- RESP:
  - PREADY=1 for exactly one cycle.
  - At that edge the write commits and the FSM returns to IDLE.
  - Back-to-back transfers are allowed: a new setup phase may occur in the cycle after RESP, and the FSM is in IDLE for that cycle.
- Register index is PADDR[2 +: clog2(NUM_REGS)].
- Error is set when any of these holds:
  - PADDR[1:0] != 0;
  - the upper address bits are non-zero (index >= NUM_REGS);
  - the transfer is a write to index 0.
- On error, no register changes, PRDATA=0 and PSLVERR=1 with PREADY.
- Read returns ID_VALUE for index 0 and the stored value otherwise. PRDATA is loaded on the edge that sets PREADY and returns to 0 on the following edge.
- Write commits latched PWDATA on the edge ending the RESP cycle, only when PSEL=1 and PENABLE=1 in that cycle.
- Abort rule (protocol violation): PSEL=0 in WAIT or RESP sends the FSM to IDLE next edge, drops PREADY, and performs no write.
- Reset, including mid-transfer:
  - State goes to IDLE, wcnt to 0, PREADY to 0, PSLVERR to 0 and PRDATA to 0.
  - Registers 1..NUM_REGS-1 clear to 0; regs_flat slice 0 always shows ID_VALUE.
  - Any in-flight write is discarded.

## Timing
- T0 = setup cycle and T1 = first access cycle.
- PREADY is high in cycle T1+WAIT_STATES and low in all other cycles.
- PRDATA and PSLVERR are valid in the same cycle as PREADY; PSLVERR is 0 whenever PREADY is 0.
- A write is visible on regs_flat one cycle after the PREADY cycle.
- Minimum transfer is 2 cycles (WAIT_STATES=0).
- A PENABLE=1 seen in IDLE without a preceding setup phase is ignored.

## Structure
- Shared package apb_pkg holds:
  - the FSM state typedef (IDLE/WAIT/RESP, 2 bits);
  - the APB response constants OKAY/ERROR;
  - a function that returns log2 of the register count.
  - The master's state encoding is also moved there.
- One natural sub-module, apb_regbank: the register array with write port, read mux and ID constant. It takes a write enable, index and data and returns read data; the completer keeps the FSM, the decode and the wait counter.

## Test plan
- WAIT_STATES=1, write 32'hDEADBEEF to 0x04, then read 0x04: PREADY high at T2 for each transfer, PSLVERR=0, PRDATA=32'hDEADBEEF, regs_flat[63:32]=32'hDEADBEEF.
- WAIT_STATES=0, back-to-back writes to 0x08 and 0x0C with no idle gap: each transfer completes in 2 cycles and both values are stored.
- Read 0x00 gives ID_VALUE with PSLVERR=0. Write 0x00 gives PSLVERR=1 and the ID is unchanged.
- Errors and no write:
  - Address 0x40 with NUM_REGS=16 gives PSLVERR=1, PRDATA=0.
  - Misaligned address 0x06 gives PSLVERR=1.
  - In both cases no register changes.
- PRESET asserted during WAIT of a write to 0x10: the next cycle has PREADY=0, reg 4 = 0, and the FSM is in IDLE. A following normal transfer succeeds.
- PSEL dropped in WAIT: no PREADY pulse and no write; the next legal transfer completes normally.
